// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: debounces scanner key levels into one key-down event per press and queues them for CPU pop-on-read
// Define KEYPAD_FIFO_REPEAT_EN to build auto-repeat events while a key stays held.
module keypad_event_fifo #(
  parameter int          DEPTH        = 8,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd4
`ifdef KEYPAD_FIFO_REPEAT_EN
  ,
  parameter logic [23:0] REPEAT_DELAY  = 24'd8,
  parameter logic [23:0] REPEAT_PERIOD = 24'd4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_val,
  input  logic       key_press,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic [7:0] rd_data,
  output logic [6:0] count,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       event_pulse
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state, state_n;
  logic [4:0] sync1, sync2, prev;
  logic [19:0] stab_cnt;
  logic [3:0] cap, cap_n;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, nh;
  logic [6:0] cnt_n;
  logic [7:0] rd_n;
  logic chg, stable, push, do_pop, wr, drop;
  wire s_press = sync2[4];
  wire [3:0] s_val = sync2[3:0];
  assign chg = sync2 != prev;
  assign stable = !chg && stab_cnt >= DEBOUNCE_CYC - 20'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      stab_cnt <= '0;
      state <= IDLE;
      cap <= '0;
    end else begin
      sync1 <= {key_press, key_val};
      sync2 <= sync1;
      prev <= sync2;
      stab_cnt <= chg ? '0 : (&stab_cnt ? stab_cnt : stab_cnt + 20'd1);
      state <= state_n;
      cap <= cap_n;
    end
`ifdef KEYPAD_FIFO_REPEAT_EN
  logic [23:0] rep_cnt;
  logic rep_first, rep_hit;
  assign rep_hit = state == HELD && s_press &&
                   rep_cnt == (rep_first ? REPEAT_DELAY : REPEAT_PERIOD) - 24'd1;
  // Counter only restarts on a fresh press; release bounces back into HELD keep its phase.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rep_cnt <= '0;
      rep_first <= 1'b1;
    end else if (state == PRESS_WAIT && state_n == HELD) begin
      rep_cnt <= '0;
      rep_first <= 1'b1;
    end else if (state == HELD && s_press) begin
      rep_cnt <= rep_hit ? '0 : rep_cnt + 24'd1;
      rep_first <= rep_hit ? 1'b0 : rep_first;
    end
`endif
  always_comb begin
    state_n = state;
    cap_n = cap;
    push = 1'b0;
    case (state)
      IDLE: if (s_press) begin
        state_n = PRESS_WAIT;
        cap_n = s_val;
      end
      PRESS_WAIT: if (!s_press || s_val != cap) state_n = IDLE;
        else if (stable) begin
          state_n = HELD;
          push = 1'b1;
        end
      HELD: begin
        if (!s_press) state_n = RELEASE_WAIT;
`ifdef KEYPAD_FIFO_REPEAT_EN
        push = rep_hit;
`endif
      end
      RELEASE_WAIT: state_n = s_press ? HELD : (stable ? IDLE : RELEASE_WAIT);
      default: state_n = IDLE;
    endcase
  end
  assign do_pop = rd_en && count != 7'd0;
  assign wr = push && (!full || do_pop);
  assign drop = push && full && !do_pop;
  assign cnt_n = count + 7'(wr) - 7'(do_pop);
  assign nh = rd_ptr + 1'b1;
  // Show-ahead head: a push into a one-entry FIFO being popped bypasses the memory.
  assign rd_n = cnt_n == 7'd0 ? 8'h00 :
                count == 7'd0 ? {4'h8, cap} :
                do_pop ? {4'h8, (wr && nh == wr_ptr) ? cap : mem[nh]} : rd_data;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= cap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_data <= 8'h00;
      overflow <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? nh : rd_ptr;
      count <= cnt_n;
      rd_data <= rd_n;
      overflow <= drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow);
      event_pulse <= push;
    end
  assign empty = count == 7'd0;
  assign full = count == 7'(DEPTH);
endmodule

// File: tb/tb_keypad_event_fifo.sv
// tb_keypad_event_fifo: directed bench for keypad_event_fifo (DEPTH=8, DEBOUNCE_CYC=4)
module tb_keypad_event_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] key_val = 4'h0;
  logic key_press = 1'b0;
  logic rd_en = 1'b0;
  logic clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic [6:0] count;
  logic empty, full, overflow, event_pulse;
  int errors = 0;
  int checks = 0;
  int ev_cnt = 0;
  int ev0;
  int exp_ev;

  keypad_event_fifo dut (
    .clk(clk), .rst_n(rst_n), .key_val(key_val), .key_press(key_press),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .event_pulse(event_pulse)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (event_pulse) ev_cnt <= ev_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key(input logic [3:0] c, input int hold);
    key_val = c;
    key_press = 1'b1;
    tick(hold);
    key_press = 1'b0;
    key_val = 4'h0;
    tick(10);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_count", count, 7'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_event_pulse", event_pulse, 1'b0);
    rst_n = 1'b1;
    tick(2);

    ev0 = ev_cnt;
    key_val = 4'h5;
    key_press = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("t1_no_early_pulse", event_pulse, 1'b0);
    end
    tick(1);
    check("t1_pulse", event_pulse, 1'b1);
    check("t1_rd_data", rd_data, 8'h85);
    check("t1_count", count, 7'd1);
    tick(1);
    check("t1_pulse_one_cycle", event_pulse, 1'b0);
    tick(2);
    key_press = 1'b0;
    key_val = 4'h0;
    tick(10);
    check("t1_single_event", ev_cnt - ev0, 1);
    check("t1_count_after", count, 7'd1);
    pop();
    check("t1_pop_count", count, 7'd0);
    check("t1_pop_empty", empty, 1'b1);
    check("t1_pop_rd_data", rd_data, 8'h00);

    ev0 = ev_cnt;
    key_val = 4'h3;
    for (int i = 0; i < 6; i++) begin
      key_press = ~key_press;
      tick(2);
    end
    key_val = 4'h0;
    tick(12);
    check("t2_no_event", ev_cnt - ev0, 0);
    check("t2_count", count, 7'd0);
    check("t2_empty", empty, 1'b1);

    ev0 = ev_cnt;
    for (int i = 1; i <= 9; i++) press_key(4'(i), 8);
    check("t3_events", ev_cnt - ev0, 9);
    check("t3_count", count, 7'd8);
    check("t3_full", full, 1'b1);
    check("t3_overflow", overflow, 1'b1);
    check("t3_head", rd_data, 8'h81);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("t3_clr_ovf", overflow, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      check("t3_pop_order", rd_data, 8'h80 | 8'(i));
      pop();
    end
    check("t3_drained_rd_data", rd_data, 8'h00);
    check("t3_drained_empty", empty, 1'b1);
    pop();
    check("t3_pop_empty_count", count, 7'd0);
    check("t3_pop_empty_rd_data", rd_data, 8'h00);

    for (int i = 1; i <= 8; i++) press_key(4'(i), 8);
    check("t4_full", full, 1'b1);
    key_val = 4'h9;
    key_press = 1'b1;
    tick(6);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("t4_pulse", event_pulse, 1'b1);
    check("t4_count", count, 7'd8);
    check("t4_overflow", overflow, 1'b0);
    check("t4_head", rd_data, 8'h82);
    tick(2);
    key_press = 1'b0;
    key_val = 4'h0;
    tick(10);
    check("t4_count_after", count, 7'd8);
    for (int i = 2; i <= 9; i++) begin
      check("t4_pop_order", rd_data, 8'h80 | 8'(i));
      pop();
    end
    check("t4_empty", empty, 1'b1);

    press_key(4'hC, 8);
    press_key(4'hD, 8);
    press_key(4'hE, 8);
    check("t5_count_pre", count, 7'd3);
    key_val = 4'hF;
    key_press = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("t5_rst_count", count, 7'd0);
    check("t5_rst_rd_data", rd_data, 8'h00);
    check("t5_rst_overflow", overflow, 1'b0);
    check("t5_rst_empty", empty, 1'b1);
    ev0 = ev_cnt;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("t5_one_event", ev_cnt - ev0, 1);
    check("t5_count", count, 7'd1);
    check("t5_rd_data", rd_data, 8'h8F);
    key_press = 1'b0;
    key_val = 4'h0;
    tick(10);
    pop();
    check("t5_drained", empty, 1'b1);

`ifdef KEYPAD_FIFO_REPEAT_EN
    exp_ev = 6;
`else
    exp_ev = 1;
`endif
    ev0 = ev_cnt;
    key_val = 4'hA;
    key_press = 1'b1;
    tick(30);
    key_press = 1'b0;
    key_val = 4'h0;
    tick(12);
    check("t6_events", ev_cnt - ev0, exp_ev);
    check("t6_count", count, 7'(exp_ev));
    check("t6_head", rd_data, 8'h8A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
